right_shift_unit: RTL and testbench

//   Multi-cycle right shifter: the inverse-direction partner of the left (normalising) shifter.

---
 rtl/right_shift_unit_pkg.sv | 13 +
 rtl/right_shift_unit_if.sv | 27 ++
 rtl/right_shift_unit_shift_down_counter.sv | 26 ++
 rtl/right_shift_unit.sv | 83 ++++++++
 tb/tb_right_shift_unit.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/right_shift_unit_pkg.sv
// Shared definitions for the multi-cycle right shifter: FSM state encoding and default sizes.
package right_shift_unit_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/right_shift_unit_if.sv
// Control/data bundle of the right shifter: load/start requests in, data and status out.
interface right_shift_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
);

  logic             ld;
  logic [WIDTH-1:0] in;
  logic             start;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             ready;
  logic             done;
  logic             sticky;

  modport master (
    output ld, in, start, shamt,
    input  out, busy, ready, done, sticky
  );

  modport slave (
    input  ld, in, start, shamt,
    output out, busy, ready, done, sticky
  );

endinterface

// File: rtl/right_shift_unit_shift_down_counter.sv
// Remaining-shift counter: parallel load, decrement by one, flags when a single shift remains.
module shift_down_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_cnt,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             is_one
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld_cnt) begin
      cnt <= cnt_in;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/right_shift_unit.sv
// Multi-cycle right shifter: one bit per clock, sticky OR of shifted-out bits, one-cycle done pulse.
module right_shift_unit
  import right_shift_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter bit ARITH = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  right_shift_unit_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] data;
  logic             sticky_q;
  logic [CNT_W-1:0] shamt_clamped;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one;
  logic             cnt_ld;
  logic             cnt_dec;
  logic             fill;

  // Amounts beyond WIDTH drain the word fully, so latency is bounded by WIDTH.
  assign shamt_clamped = (bus.shamt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : bus.shamt;
  assign fill          = ARITH ? data[WIDTH-1] : 1'b0;

  assign cnt_ld  = (state == S_IDLE) && !bus.ld && bus.start;
  assign cnt_dec = (state == S_SHIFT);

  shift_down_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld_cnt (cnt_ld),
    .cnt_in (shamt_clamped),
    .dec    (cnt_dec),
    .cnt    (cnt),
    .is_one (cnt_is_one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      data     <= '0;
      sticky_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ld) begin
            data     <= bus.in;
            sticky_q <= 1'b0;
          end else if (bus.start) begin
            sticky_q <= 1'b0;
            state    <= (shamt_clamped != '0) ? S_SHIFT : S_DONE;
          end
        end
        S_SHIFT: begin
          data     <= {fill, data[WIDTH-1:1]};
          sticky_q <= sticky_q | data[0];
          // A zero count here can only be reached by corruption; exit rather than spin.
          if (cnt_is_one || (cnt == '0)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.out    = data;
  assign bus.sticky = sticky_q;
  assign bus.busy   = (state == S_SHIFT);
  assign bus.ready  = (state == S_IDLE);
  assign bus.done   = (state == S_DONE);

endmodule

// File: tb/tb_right_shift_unit.sv
// Directed and random checks of logical and arithmetic right_shift_unit instances side by side.
module tb_right_shift_unit;

  logic        clk;
  logic        rst;
  logic        ld;
  logic [15:0] in_v;
  logic        start;
  logic [4:0]  shamt;

  int checks = 0;
  int errors = 0;

  logic [15:0] cur0, cur1;

  right_shift_unit_if #(.WIDTH(16), .CNT_W(5)) bus0 ();
  right_shift_unit_if #(.WIDTH(16), .CNT_W(5)) bus1 ();

  assign bus0.ld = ld;  assign bus0.in = in_v;  assign bus0.start = start;  assign bus0.shamt = shamt;
  assign bus1.ld = ld;  assign bus1.in = in_v;  assign bus1.start = start;  assign bus1.shamt = shamt;

  right_shift_unit #(.WIDTH(16), .CNT_W(5), .ARITH(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  right_shift_unit #(.WIDTH(16), .CNT_W(5), .ARITH(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Optionally load val, then shift by sh; compare timing and result against plain arithmetic.
  task automatic run(input string tag, input bit do_ld, input logic [15:0] val,
                     input logic [4:0] sh, input bit glitch);
    int n, busy_n, done_n, done_at;
    bit seen_ready;
    logic [15:0] e0, e1;
    logic signed [15:0] s1;
    logic [31:0] mask;
    logic st0, st1;
    if (do_ld) begin
      ld = 1'b1; in_v = val;
      tick();
      ld = 1'b0;
      cur0 = val; cur1 = val;
    end
    n    = (int'(sh) > 16) ? 16 : int'(sh);
    s1   = cur1;
    mask = (32'd1 << n) - 32'd1;
    e0   = cur0 >> n;
    e1   = s1 >>> n;
    st0  = |({16'd0, cur0} & mask);
    st1  = |({16'd0, cur1} & mask);
    start = 1'b1; shamt = sh;
    tick();
    start = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1; seen_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus0.ready) begin
        seen_ready = 1'b1;
        break;
      end
      if (bus0.busy) busy_n++;
      if (bus0.done) begin
        done_n++;
        done_at = c;
      end
      if (glitch && c == 1) begin
        ld = 1'b1; in_v = 16'hFFFF; start = 1'b1; shamt = 5'd1;
      end
      if (glitch && c == 2) begin
        ld = 1'b0; start = 1'b0;
      end
      tick();
    end
    ld = 1'b0; start = 1'b0;
    chk({tag, " ready_back"}, 32'(seen_ready), 32'd1);
    chk({tag, " busy_cycles"}, busy_n, n);
    chk({tag, " done_pulses"}, done_n, 1);
    chk({tag, " done_cycle"}, done_at, n);
    chk({tag, " out_logical"}, bus0.out, e0);
    chk({tag, " out_arith"}, bus1.out, e1);
    chk({tag, " sticky_logical"}, 32'(bus0.sticky), 32'(st0));
    chk({tag, " sticky_arith"}, 32'(bus1.sticky), 32'(st1));
    cur0 = e0; cur1 = e1;
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; in_v = '0; start = 1'b0; shamt = '0;
    cur0 = '0; cur1 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out", bus0.out, 32'd0);
    chk("reset ready", 32'(bus0.ready), 32'd1);
    chk("reset busy", 32'(bus0.busy), 32'd0);
    chk("reset done", 32'(bus0.done), 32'd0);
    chk("reset sticky", 32'(bus0.sticky), 32'd0);
    chk("reset out arith", bus1.out, 32'd0);
    rst = 1'b0;
    tick();

    // Known vectors: logical 0001110111011101, arithmetic 1111110111011101, sticky 1.
    run("t1", 1'b1, 16'b1110111011101010, 5'd3, 1'b0);
    chk("t1 literal logical", bus0.out, 32'h1DDD);
    chk("t1 literal arith", bus1.out, 32'hFDDD);

    run("t3a", 1'b1, 16'hF0F0, 5'd4, 1'b0);
    chk("t3a literal logical", bus0.out, 32'h0F0F);
    run("t3b_zero", 1'b0, 16'h0000, 5'd0, 1'b0);
    chk("t3b literal logical", bus0.out, 32'h0F0F);

    run("t4_clamp", 1'b1, 16'h8001, 5'd20, 1'b0);

    // ld and start together: ld wins and no shift begins.
    ld = 1'b1; in_v = 16'h1234; start = 1'b1; shamt = 5'd2;
    tick();
    ld = 1'b0; start = 1'b0;
    chk("t5 ld_prio out", bus0.out, 32'h1234);
    chk("t5 ld_prio ready", 32'(bus0.ready), 32'd1);
    chk("t5 ld_prio busy", 32'(bus0.busy), 32'd0);
    tick();
    chk("t5 stays idle", 32'(bus0.ready), 32'd1);
    cur0 = 16'h1234; cur1 = 16'h1234;
    run("t5_glitch", 1'b0, 16'h0000, 5'd5, 1'b1);

    // Asynchronous reset two cycles into a 5-bit shift.
    ld = 1'b1; in_v = 16'hBEEF;
    tick();
    ld = 1'b0; start = 1'b1; shamt = 5'd5;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t6 busy before rst", 32'(bus0.busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("t6 rst out", bus0.out, 32'd0);
    chk("t6 rst ready", 32'(bus0.ready), 32'd1);
    chk("t6 rst busy", 32'(bus0.busy), 32'd0);
    chk("t6 rst sticky", 32'(bus0.sticky), 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6 no done", 32'(bus0.done) | 32'(bus1.done), 32'd0);
    end
    rst = 1'b0;
    cur0 = '0; cur1 = '0;
    tick();

    for (int i = 0; i < 24; i++) begin
      run($sformatf("rand%0d", i), ($urandom_range(0, 3) != 0), 16'($urandom),
          5'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
